// File: rtl/game_ctrl.sv
// Two-player chess-clock controller: turn, pause and flag FSM with a registered output decode.
// Optional macro GAME_CTRL_INCREMENT_EN adds one-cycle increment pulses on each turn handover.
module game_ctrl #(
    parameter int MOVE_W = 8
) (
    input  logic              CLK,
    input  logic              CLR,
    input  logic              CE,
    input  logic              BTN_P1,
    input  logic              BTN_P2,
    input  logic              BTN_PAUSE,
    input  logic              ZERO_P1,
    input  logic              ZERO_P2,
    output logic              SELECT,
    output logic              STOP,
    output logic              LOAD,
    output logic              INC_P1,
    output logic              INC_P2,
    output logic              FLAG_P1,
    output logic              FLAG_P2,
    output logic [MOVE_W-1:0] MOVES,
    output logic [2:0]        STATE
);
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RUN_P1 = 3'd1,
        RUN_P2 = 3'd2,
        PAUSED = 3'd3,
        FLAG   = 3'd4
    } state_t;

    state_t            state, state_nxt;
    logic              saved, saved_nxt;
    logic              sel_nxt, stop_nxt, load_nxt, flag_p1_nxt, flag_p2_nxt;
    logic [MOVE_W-1:0] moves_nxt;
    logic              hand_p1, hand_p2;

    // A handover only wins when neither a flag nor a pause outranks it.
    assign hand_p1 = CE && state == RUN_P1 && !ZERO_P1 && !BTN_PAUSE && BTN_P1;
    assign hand_p2 = CE && state == RUN_P2 && !ZERO_P2 && !BTN_PAUSE && BTN_P2;

    always_ff @(posedge CLK) begin
        if (CLR) begin
            state   <= IDLE;
            saved   <= 1'b0;
            SELECT  <= 1'b0;
            STOP    <= 1'b1;
            LOAD    <= 1'b1;
            FLAG_P1 <= 1'b0;
            FLAG_P2 <= 1'b0;
            MOVES   <= '0;
        end else begin
            state   <= state_nxt;
            saved   <= saved_nxt;
            SELECT  <= sel_nxt;
            STOP    <= stop_nxt;
            LOAD    <= load_nxt;
            FLAG_P1 <= flag_p1_nxt;
            FLAG_P2 <= flag_p2_nxt;
            MOVES   <= moves_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        saved_nxt = saved;
        if (CE) begin
            unique case (state)
                IDLE:   if (BTN_P2) state_nxt = RUN_P1;
                RUN_P1: begin
                    if (ZERO_P1)        state_nxt = FLAG;
                    else if (BTN_PAUSE) begin
                        state_nxt = PAUSED;
                        saved_nxt = 1'b0;
                    end
                    else if (BTN_P1)    state_nxt = RUN_P2;
                end
                RUN_P2: begin
                    if (ZERO_P2)        state_nxt = FLAG;
                    else if (BTN_PAUSE) begin
                        state_nxt = PAUSED;
                        saved_nxt = 1'b1;
                    end
                    else if (BTN_P2)    state_nxt = RUN_P1;
                end
                PAUSED: if (BTN_PAUSE) state_nxt = saved ? RUN_P2 : RUN_P1;
                default: state_nxt = state;
            endcase
        end
    end

    always_comb begin
        sel_nxt     = SELECT;
        stop_nxt    = 1'b1;
        load_nxt    = 1'b0;
        flag_p1_nxt = FLAG_P1 | (CE && state == RUN_P1 && ZERO_P1);
        flag_p2_nxt = FLAG_P2 | (CE && state == RUN_P2 && ZERO_P2);
        moves_nxt   = MOVES;
        if ((hand_p1 || hand_p2) && MOVES != {MOVE_W{1'b1}})
            moves_nxt = MOVES + MOVE_W'(1);
        case (state_nxt)
            IDLE: begin
                sel_nxt  = 1'b0;
                load_nxt = 1'b1;
            end
            RUN_P1: begin
                sel_nxt  = 1'b0;
                stop_nxt = 1'b0;
            end
            RUN_P2: begin
                sel_nxt  = 1'b1;
                stop_nxt = 1'b0;
            end
            default: ;
        endcase
    end

`ifdef GAME_CTRL_INCREMENT_EN
    always_ff @(posedge CLK) begin
        if (CLR) begin
            INC_P1 <= 1'b0;
            INC_P2 <= 1'b0;
        end else begin
            INC_P1 <= hand_p1;
            INC_P2 <= hand_p2;
        end
    end
`else
    assign INC_P1 = 1'b0;
    assign INC_P2 = 1'b0;
`endif

    assign STATE = state;
endmodule

// File: tb/tb_game_ctrl.sv
// Directed bench for game_ctrl: a vector table walked from reset, then a few hand-written sequences.
module tb_game_ctrl;
    localparam int MW = 2;
`ifdef GAME_CTRL_INCREMENT_EN
    localparam logic INC = 1'b1;
`else
    localparam logic INC = 1'b0;
`endif

    logic clk = 1'b0;
    logic clr, ce, b1, b2, bp, z1, z2;
    logic sel, stop, load, inc1, inc2, f1, f2;
    logic [MW-1:0] moves;
    logic [2:0] st;
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    game_ctrl #(.MOVE_W(MW)) dut (
        .CLK(clk), .CLR(clr), .CE(ce), .BTN_P1(b1), .BTN_P2(b2), .BTN_PAUSE(bp),
        .ZERO_P1(z1), .ZERO_P2(z2), .SELECT(sel), .STOP(stop), .LOAD(load),
        .INC_P1(inc1), .INC_P2(inc2), .FLAG_P1(f1), .FLAG_P2(f2), .MOVES(moves), .STATE(st)
    );

    // in = {clr,ce,b1,b2,bp,z1,z2}; exp = {state,sel,stop,load,inc1,inc2,f1,f2,moves}
    typedef struct {
        logic [6:0]  in;
        logic [11:0] exp;
    } vec_t;

    function automatic logic [11:0] e(input logic [2:0] s, input logic sl, input logic sp,
                                      input logic ld, input logic i1, input logic i2,
                                      input logic g1, input logic g2, input logic [1:0] m);
        return {s, sl, sp, ld, i1, i2, g1, g2, m};
    endfunction

    task automatic step(input logic [6:0] in);
        {clr, ce, b1, b2, bp, z1, z2} = in;
        @(posedge clk);
        #1;
        {clr, ce, b1, b2, bp, z1, z2} = 7'b0;
    endtask

    task automatic check(input string name, input logic [11:0] exp);
        logic [11:0] act;
        act = {st, sel, stop, load, inc1, inc2, f1, f2, moves};
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b, expected %b (state,sel,stop,load,inc1,inc2,f1,f2,moves)",
                     name, act, exp);
        end
    endtask

    vec_t tbl[25];

    initial begin
        {clr, ce, b1, b2, bp, z1, z2} = 7'b0;
        tbl[0]  = '{7'b1000000, e(0,0,1,1,0,0,0,0,0)};   // reset
        tbl[1]  = '{7'b0100000, e(0,0,1,1,0,0,0,0,0)};
        tbl[2]  = '{7'b0110000, e(0,0,1,1,0,0,0,0,0)};   // BTN_P1 ignored in IDLE
        tbl[3]  = '{7'b0101000, e(1,0,0,0,0,0,0,0,0)};   // start
        tbl[4]  = '{7'b0110000, e(2,1,0,0,INC,0,0,0,1)}; // handover P1->P2
        tbl[5]  = '{7'b0100000, e(2,1,0,0,0,0,0,0,1)};   // INC only one cycle
        tbl[6]  = '{7'b0100100, e(3,1,1,0,0,0,0,0,1)};   // pause
        tbl[7]  = '{7'b0110000, e(3,1,1,0,0,0,0,0,1)};
        tbl[8]  = '{7'b0100001, e(3,1,1,0,0,0,0,0,1)};   // ZERO ignored when paused
        tbl[9]  = '{7'b0100100, e(2,1,0,0,0,0,0,0,1)};   // resume to P2
        tbl[10] = '{7'b0101000, e(1,0,0,0,0,INC,0,0,2)};
        tbl[11] = '{7'b0010000, e(1,0,0,0,0,0,0,0,2)};   // CE=0 drops the event
        tbl[12] = '{7'b0101001, e(1,0,0,0,0,0,0,0,2)};   // other side ignored
        tbl[13] = '{7'b0110000, e(2,1,0,0,INC,0,0,0,3)};
        tbl[14] = '{7'b0101000, e(1,0,0,0,0,INC,0,0,3)}; // saturated
        tbl[15] = '{7'b0110000, e(2,1,0,0,INC,0,0,0,3)};
        tbl[16] = '{7'b0100100, e(3,1,1,0,0,0,0,0,3)};
        tbl[17] = '{7'b0000100, e(3,1,1,0,0,0,0,0,3)};   // CE=0 pause ignored
        tbl[18] = '{7'b0100100, e(2,1,0,0,0,0,0,0,3)};
        tbl[19] = '{7'b0101101, e(4,1,1,0,0,0,0,1,3)};   // P2 collision -> flag
        tbl[20] = '{7'b0101100, e(4,1,1,0,0,0,0,1,3)};   // terminal
        tbl[21] = '{7'b1000000, e(0,0,1,1,0,0,0,0,0)};   // clear from FLAG, CE=0
        tbl[22] = '{7'b0101000, e(1,0,0,0,0,0,0,0,0)};
        tbl[23] = '{7'b0110110, e(4,0,1,0,0,0,1,0,0)};   // P1 collision
        tbl[24] = '{7'b1100000, e(0,0,1,1,0,0,0,0,0)};

        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 25; i++) begin
            step(tbl[i].in);
            check($sformatf("vec%0d", i), tbl[i].exp);
        end

        // Pause from RUN_P1 must resume to RUN_P1 and keep SELECT=0.
        step(7'b0101000);
        step(7'b0100100);
        check("pause_p1", e(3,0,1,0,0,0,0,0,0));
        step(7'b0101000);
        check("paused_btn_p2", e(3,0,1,0,0,0,0,0,0));
        step(7'b0100100);
        check("resume_p1", e(1,0,0,0,0,0,0,0,0));

        // Clear while paused from P2 with a move on the counter, then restart.
        step(7'b0110000);
        step(7'b0100100);
        check("pause_p2", e(3,1,1,0,0,0,0,0,1));
        step(7'b1100100);
        check("clr_paused", e(0,0,1,1,0,0,0,0,0));
        step(7'b0100100);
        check("idle_pause_ignored", e(0,0,1,1,0,0,0,0,0));
        step(7'b0101000);
        check("restart", e(1,0,0,0,0,0,0,0,0));
        step(7'b0100010);
        check("zero_p1_flag", e(4,0,1,0,0,0,1,0,0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/game_ctrl.md
GAME_CTRL -- requirements
Module: game_ctrl

Interface
REQ-001 Parameter MOVE_W, default 8, sets the width of the half-move counter.
REQ-002 CLK  input  1  system clock; all state updates occur on the rising edge.
REQ-003 CLR  input  1  synchronous, active-high reset.
REQ-004 CE  input  1  clock enable; event inputs are sampled only when CE=1.
REQ-005 BTN_P1  input  1  single-cycle debounced pulse; player 1 ends turn.
REQ-006 BTN_P2  input  1  single-cycle debounced pulse; player 2 ends turn, or starts the game from IDLE.
REQ-007 BTN_PAUSE  input  1  single-cycle pulse; toggles pause.
REQ-008 ZERO_P1, ZERO_P2  input  1 each  time-expired flags from the player counters.
REQ-009 SELECT  output  1  active side to the enable switch: 0=P1, 1=P2.
REQ-010 STOP  output  1  freezes both player timers when high.
REQ-011 LOAD  output  1  high while in IDLE; holds the counters at the preset time.
REQ-012 INC_P1, INC_P2  output  1 each  one-cycle increment-add pulses.
REQ-013 FLAG_P1, FLAG_P2  output  1 each  loss-on-time indicators.
REQ-014 MOVES  output  MOVE_W  half-move count.
REQ-015 STATE  output  3  encoding: IDLE=0, RUN_P1=1, RUN_P2=2, PAUSED=3, FLAG=4.

Function
REQ-016 The block SHALL implement the FSM states IDLE, RUN_P1, RUN_P2, PAUSED and FLAG, plus a 1-bit saved-side register.
REQ-017 All outputs SHALL be registered; an event sampled at edge n SHALL be visible on the outputs immediately after edge n.
REQ-018 When CE=0, state, MOVES and the saved side SHALL hold, INC_P1 and INC_P2 SHALL be 0, and input events SHALL be discarded.
REQ-019 IDLE: BTN_P2 -> RUN_P1; all other inputs are ignored.
REQ-020 RUN_P1: transition priority is ZERO_P1 -> FLAG (FLAG_P1=1), then BTN_PAUSE -> PAUSED (saved side=P1), then BTN_P1 -> RUN_P2 (MOVES+1); BTN_P2 and ZERO_P2 are ignored.
REQ-021 RUN_P2: mirror of REQ-020 with P1 and P2 swapped.
REQ-022 PAUSED: BTN_PAUSE -> the saved RUN state; player buttons and ZERO inputs are ignored.
REQ-023 FLAG: terminal state; left only via CLR; the FLAG_Px set on entry SHALL be held.
REQ-024 Output decode: STOP=1 in IDLE, PAUSED and FLAG; SELECT=0 in RUN_P1 and IDLE, 1 in RUN_P2; in PAUSED and FLAG, SELECT holds the last active side.
REQ-025 MOVES SHALL saturate at 2^MOVE_W-1 and SHALL NOT wrap.
REQ-026 A turn handover and a same-cycle ZERO for the moving player SHALL resolve to FLAG: no MOVES increment and no INC pulse.

Reset
REQ-027 CLR=1 at a clock edge SHALL force IDLE regardless of CE or the current state.
REQ-028 Reset values: SELECT=0, STOP=1, LOAD=1, INC_P1=0, INC_P2=0, FLAG_P1=0, FLAG_P2=0, MOVES=0, STATE=0, saved side=P1.
REQ-029 CLR asserted mid-game, including in PAUSED or FLAG, SHALL discard all game state in the same cycle.

Configuration
REQ-030 Macro GAME_CTRL_INCREMENT_EN, when defined, SHALL make each handover RUN_P1->RUN_P2 pulse INC_P1 for one cycle, and each handover RUN_P2->RUN_P1 pulse INC_P2 for one cycle.
REQ-031 When GAME_CTRL_INCREMENT_EN is undefined, INC_P1 and INC_P2 SHALL be tied to 0 and no increment logic SHALL be synthesized; all other behaviour is unchanged.

Verification
REQ-032 Start: CLR=1 for 1 cycle, then CE=1 and a BTN_P2 pulse -> STATE=1, SELECT=0, STOP=0, LOAD=0, MOVES=0.
REQ-033 Handover: from RUN_P1, pulse BTN_P1 -> STATE=2, SELECT=1, MOVES=1; with the macro defined, INC_P1=1 for exactly one cycle.
REQ-034 Pause: in RUN_P2, pulse BTN_PAUSE -> STATE=3, STOP=1, SELECT=1; pulse BTN_P1 -> no change; pulse BTN_PAUSE -> STATE=2, STOP=0.
REQ-035 Collision: in RUN_P1, assert ZERO_P1, BTN_P1 and BTN_PAUSE in the same cycle -> STATE=4, FLAG_P1=1, STOP=1, MOVES unchanged, INC_P1=0.
REQ-036 Gating and saturation: with MOVE_W=2, perform 5 handovers -> MOVES=3; a BTN pulse with CE=0 -> no state change.
REQ-037 Reset from FLAG: CLR=1 -> all outputs at the REQ-028 values on the next cycle.
